// File: rtl/fcc_cmd_dispatcher.sv
// FCC command dispatcher: decodes host commands into NAND micro-ops, gates issue on
// buffer space / write data, supervises completion with a timeout, returns one completion.
module fcc_cmd_dispatcher #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000,
   parameter int          WORD_BYTES     = 4
) (
   input  logic        nand_usr_clk,
   input  logic        nand_usr_rstn,
   output logic        o_cmd_ready,
   input  logic        i_cmd_valid,
   input  logic [15:0] i_cmd,
   input  logic [15:0] i_cmd_id,
   input  logic [47:0] i_addr,
   input  logic [23:0] i_len,
   input  logic [63:0] i_data,
   input  logic [7:0]  i_col_num,
   input  logic [63:0] i_col_addr_len,
   input  logic        i_rpage_buf_ready,
   input  logic [23:0] i_wdata_avail,
   output logic        o_op_valid,
   input  logic        i_op_ready,
   output logic [3:0]  o_op_code,
   output logic [7:0]  o_op_tgt,
   output logic [23:0] o_op_row,
   output logic [15:0] o_op_col,
   output logic [23:0] o_op_len,
   output logic [63:0] o_op_data,
   output logic [15:0] o_op_id,
   input  logic        i_op_done,
   input  logic [7:0]  i_op_status,
   output logic        o_cpl_valid,
   input  logic        i_cpl_ready,
   output logic [15:0] o_cpl_id,
   output logic [7:0]  o_cpl_status,
   output logic        o_busy,
   output logic [2:0]  o_state
);

   // Handshakes: a transfer happens on a clock edge where valid & ready are both high;
   // once raised, valid and its payload stay stable until that transfer.

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DECODE    = 3'd1,
      S_GATE      = 3'd2,
      S_ISSUE     = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_NEXT_COL  = 3'd5,
      S_CPL       = 3'd6
   } state_t;

   localparam logic [3:0] OP_RESET        = 4'd1;
   localparam logic [3:0] OP_READ_PAGE    = 4'd2;
   localparam logic [3:0] OP_CHG_READ_COL = 4'd3;
   localparam logic [3:0] OP_PROGRAM      = 4'd4;
   localparam logic [3:0] OP_ERASE        = 4'd5;
   localparam logic [3:0] OP_READ_STATUS  = 4'd6;
   localparam logic [3:0] OP_READ_ID      = 4'd7;
   localparam logic [3:0] OP_SET_FEATURE  = 4'd8;

   localparam logic [7:0] ST_BAD_OPCODE = 8'h80;
   localparam logic [7:0] ST_BAD_COLS   = 8'h81;
   localparam logic [7:0] ST_TIMEOUT    = 8'hFE;

   state_t      state, state_nxt;
   logic        cmd_ready_nxt, op_valid_nxt, cpl_valid_nxt, busy_nxt;
   logic [3:0]  op_code_nxt;
   logic [7:0]  op_tgt_nxt;
   logic [23:0] op_row_nxt;
   logic [15:0] op_col_nxt;
   logic [23:0] op_len_nxt;
   logic [63:0] op_data_nxt;
   logic [15:0] op_id_nxt;
   logic [15:0] cpl_id_nxt;
   logic [7:0]  cpl_status_nxt;
   logic [31:0] timer, timer_nxt;
   logic [7:0]  status_r, status_nxt;
   logic [1:0]  col_idx, col_idx_nxt;
   logic [1:0]  cols_r, cols_nxt;
   logic        capture;

   logic [7:0]  opcode_r;
   logic [15:0] cmd_id_r;
   logic [47:0] addr_r;
   logic [23:0] len_r;
   logic [63:0] data_r;
   logic [7:0]  col_num_r;
   logic [63:0] col_addr_len_r;

   logic [3:0]  dec_code;
   logic        dec_err;
   logic [7:0]  dec_status;
   logic        gate_ok;
   logic [24:0] words_needed;
   logic [31:0] col_entry;
   logic        unused_cmd_bits;

   assign unused_cmd_bits = ^i_cmd[15:8];
   assign o_state         = state;

   // Capture register: the command is latched once, on the accepting edge.
   always_ff @(posedge nand_usr_clk or negedge nand_usr_rstn) begin
      if (!nand_usr_rstn) begin
         opcode_r       <= '0;
         cmd_id_r       <= '0;
         addr_r         <= '0;
         len_r          <= '0;
         data_r         <= '0;
         col_num_r      <= '0;
         col_addr_len_r <= '0;
      end else if (capture) begin
         opcode_r       <= i_cmd[7:0];
         cmd_id_r       <= i_cmd_id;
         addr_r         <= i_addr;
         len_r          <= i_len;
         data_r         <= i_data;
         col_num_r      <= i_col_num;
         col_addr_len_r <= i_col_addr_len;
      end
   end

   always_comb begin
      dec_code   = OP_RESET;
      dec_err    = 1'b0;
      dec_status = 8'h00;
      case (opcode_r)
         8'h00: dec_code = OP_RESET;
         8'h01: begin
            dec_code = OP_READ_PAGE;
            if (col_num_r > 8'd2) begin
               dec_err    = 1'b1;
               dec_status = ST_BAD_COLS;
            end
         end
         8'h02: dec_code = OP_PROGRAM;
         8'h03: dec_code = OP_ERASE;
         8'h04: dec_code = OP_READ_STATUS;
         8'h05: dec_code = OP_READ_ID;
         8'h06: dec_code = OP_SET_FEATURE;
         default: begin
            dec_err    = 1'b1;
            dec_status = ST_BAD_OPCODE;
         end
      endcase
   end

   // Word count is formed in 25 bits so a full 24-bit length cannot overflow the round-up.
   assign words_needed = ({1'b0, o_op_len} + 25'(WORD_BYTES - 1)) / 25'(WORD_BYTES);
   assign col_entry    = col_idx[0] ? col_addr_len_r[63:32] : col_addr_len_r[31:0];

   always_comb begin
      gate_ok = 1'b1;
      case (o_op_code)
         OP_READ_PAGE, OP_CHG_READ_COL, OP_READ_ID, OP_READ_STATUS: gate_ok = i_rpage_buf_ready;
         OP_PROGRAM: gate_ok = ({1'b0, i_wdata_avail} >= words_needed);
         default:    gate_ok = 1'b1;
      endcase
   end

   always_comb begin
      state_nxt      = state;
      cmd_ready_nxt  = o_cmd_ready;
      op_valid_nxt   = o_op_valid;
      op_code_nxt    = o_op_code;
      op_tgt_nxt     = o_op_tgt;
      op_row_nxt     = o_op_row;
      op_col_nxt     = o_op_col;
      op_len_nxt     = o_op_len;
      op_data_nxt    = o_op_data;
      op_id_nxt      = o_op_id;
      cpl_valid_nxt  = o_cpl_valid;
      cpl_id_nxt     = o_cpl_id;
      cpl_status_nxt = o_cpl_status;
      timer_nxt      = timer;
      status_nxt     = status_r;
      col_idx_nxt    = col_idx;
      cols_nxt       = cols_r;
      capture        = 1'b0;

      case (state)
         S_IDLE: begin
            if (o_cmd_ready && i_cmd_valid) begin
               capture       = 1'b1;
               cmd_ready_nxt = 1'b0;
               state_nxt     = S_DECODE;
            end else begin
               cmd_ready_nxt = 1'b1;
            end
         end
         S_DECODE: begin
            status_nxt  = 8'h00;
            col_idx_nxt = 2'd0;
            cols_nxt    = (dec_code == OP_READ_PAGE && !dec_err) ? col_num_r[1:0] : 2'd0;
            op_code_nxt = dec_code;
            op_tgt_nxt  = addr_r[47:40];
            op_row_nxt  = addr_r[39:16];
            op_col_nxt  = addr_r[15:0];
            op_len_nxt  = len_r;
            op_data_nxt = data_r;
            op_id_nxt   = cmd_id_r;
            if (dec_err) begin
               cpl_valid_nxt  = 1'b1;
               cpl_id_nxt     = cmd_id_r;
               cpl_status_nxt = dec_status;
               state_nxt      = S_CPL;
            end else begin
               state_nxt = S_GATE;
            end
         end
         S_GATE: begin
            if (gate_ok) begin
               op_valid_nxt = 1'b1;
               state_nxt    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (i_op_ready) begin
               op_valid_nxt = 1'b0;
               timer_nxt    = 32'd0;
               state_nxt    = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            timer_nxt = timer + 32'd1;
            // A done pulse on the expiry cycle still counts as a normal completion.
            if (i_op_done) begin
               if (status_r == 8'h00) status_nxt = i_op_status;
               if (col_idx < cols_r) begin
                  state_nxt = S_NEXT_COL;
               end else begin
                  cpl_valid_nxt  = 1'b1;
                  cpl_id_nxt     = cmd_id_r;
                  cpl_status_nxt = (status_r != 8'h00) ? status_r : i_op_status;
                  state_nxt      = S_CPL;
               end
            end else if (timer == TIMEOUT_CYCLES - 32'd1) begin
               if (status_r == 8'h00) status_nxt = ST_TIMEOUT;
               cpl_valid_nxt  = 1'b1;
               cpl_id_nxt     = cmd_id_r;
               cpl_status_nxt = (status_r != 8'h00) ? status_r : ST_TIMEOUT;
               state_nxt      = S_CPL;
            end
         end
         S_NEXT_COL: begin
            op_code_nxt = OP_CHG_READ_COL;
            op_col_nxt  = col_entry[15:0];
            op_len_nxt  = {8'h00, col_entry[31:16]};
            col_idx_nxt = col_idx + 2'd1;
            state_nxt   = S_GATE;
         end
         S_CPL: begin
            if (i_cpl_ready) begin
               cpl_valid_nxt = 1'b0;
               cmd_ready_nxt = 1'b1;
               state_nxt     = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

   always_ff @(posedge nand_usr_clk or negedge nand_usr_rstn) begin
      if (!nand_usr_rstn) begin
         state        <= S_IDLE;
         o_cmd_ready  <= 1'b0;
         o_op_valid   <= 1'b0;
         o_op_code    <= '0;
         o_op_tgt     <= '0;
         o_op_row     <= '0;
         o_op_col     <= '0;
         o_op_len     <= '0;
         o_op_data    <= '0;
         o_op_id      <= '0;
         o_cpl_valid  <= 1'b0;
         o_cpl_id     <= '0;
         o_cpl_status <= '0;
         o_busy       <= 1'b0;
         timer        <= '0;
         status_r     <= '0;
         col_idx      <= '0;
         cols_r       <= '0;
      end else begin
         state        <= state_nxt;
         o_cmd_ready  <= cmd_ready_nxt;
         o_op_valid   <= op_valid_nxt;
         o_op_code    <= op_code_nxt;
         o_op_tgt     <= op_tgt_nxt;
         o_op_row     <= op_row_nxt;
         o_op_col     <= op_col_nxt;
         o_op_len     <= op_len_nxt;
         o_op_data    <= op_data_nxt;
         o_op_id      <= op_id_nxt;
         o_cpl_valid  <= cpl_valid_nxt;
         o_cpl_id     <= cpl_id_nxt;
         o_cpl_status <= cpl_status_nxt;
         o_busy       <= busy_nxt;
         timer        <= timer_nxt;
         status_r     <= status_nxt;
         col_idx      <= col_idx_nxt;
         cols_r       <= cols_nxt;
      end
   end

endmodule
